// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity check sequencer.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int nib_w(input int nib);
        return (nib <= 2) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/parity_nibble_xor.sv
// Shared 4-input XOR stage: P=1 when the nibble holds an odd number of ones.
module parity_nibble_xor (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic P
);

    assign P = A ^ B ^ C ^ D;

endmodule

// File: rtl/parity_check_sequencer.sv
// Walks a latched word one nibble per cycle through a single XOR stage,
// folds in the even-parity bit, and hands off pass/fail with a saturating
// error counter.
//
// state | meaning
// IDLE  | ready for a new word (in_ready=1 unless in reset)
// SCAN  | folding one nibble per cycle into the accumulator
// DONE  | result presented, waiting for res_ready
module parity_check_sequencer
    import parity_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_parity,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_err,
    output logic [WORD_W-1:0] res_data,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clr_count,
    output logic              busy
);

    localparam int NIB   = WORD_W / 4;
    localparam int NIB_W = nib_w(NIB);
    localparam logic [NIB_W-1:0] LAST_IDX = NIB_W'(NIB - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (((WORD_W % 4) != 0) || (WORD_W < 4)) begin : g_bad_width
        $error("parity_check_sequencer: WORD_W must be a multiple of 4 and >= 4");
    end

    seq_state_t        r_state;
    logic [NIB_W-1:0]  r_idx;
    logic              r_acc;
    logic [WORD_W-1:0] r_data_q;
    logic              r_res_err;
    logic [CNT_W-1:0]  r_cnt;

    logic [WORD_W-1:0] w_shifted;
    logic [3:0]        w_nib;
    logic              w_nib_p;
    logic              w_accept;
    logic              w_handoff;

    // Select the nibble addressed by the index for the shared XOR stage.
    assign w_shifted = r_data_q >> {r_idx, 2'b00};
    assign w_nib     = w_shifted[3:0];

    parity_nibble_xor u_nib_xor (
        .A (w_nib[0]),
        .B (w_nib[1]),
        .C (w_nib[2]),
        .D (w_nib[3]),
        .P (w_nib_p)
    );

    // in_ready is gated by rst so nothing is accepted on a reset edge.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign res_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign res_err   = r_res_err;
    assign res_data  = r_data_q;
    assign err_count = r_cnt;

    assign w_accept  = in_valid && in_ready;
    assign w_handoff = res_valid && res_ready;

    // Sequencer FSM, nibble walk and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_acc     <= 1'b0;
            r_data_q  <= '0;
            r_res_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data_q <= in_data;
                        r_acc    <= in_parity;
                        r_idx    <= '0;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    r_acc <= r_acc ^ w_nib_p;
                    r_idx <= r_idx + NIB_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_res_err <= r_acc ^ w_nib_p;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating error counter; a clear beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_count) begin
            r_cnt <= '0;
        end else if (w_handoff && r_res_err && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_check_sequencer.sv
// Directed bench for parity_check_sequencer: a default instance and a
// CNT_W=2 instance share the same stimulus.
module tb_parity_check_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_parity;
    logic        res_ready;
    logic        clr_count;

    logic        in_ready, res_valid, res_err, busy;
    logic [15:0] res_data;
    logic [7:0]  err_count;

    logic        in_ready2, res_valid2, res_err2, busy2;
    logic [15:0] res_data2;
    logic [1:0]  err_count2;

    int tests = 0;
    int fails = 0;

    parity_check_sequencer #(.WORD_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_parity(in_parity), .res_valid(res_valid),
        .res_ready(res_ready), .res_err(res_err), .res_data(res_data),
        .err_count(err_count), .clr_count(clr_count), .busy(busy)
    );

    parity_check_sequencer #(.WORD_W(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_parity(in_parity), .res_valid(res_valid2),
        .res_ready(res_ready), .res_err(res_err2), .res_data(res_data2),
        .err_count(err_count2), .clr_count(clr_count), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word and take it on the next edge where in_ready is high.
    task automatic accept(input logic [15:0] d, input logic p);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check("accept_ready_timeout", 32'(n < 30), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_parity = p;
        tick();
        in_valid  = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_in_scan", 32'(in_ready), 32'd0);
    endtask

    // Wait for the result, check latency and contents; no handshake.
    task automatic wait_result(input logic exp_err, input logic [15:0] exp_data);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check("result_latency", 32'(n), 32'd4);
        check("res_err", 32'(res_err), 32'(exp_err));
        check("res_data", 32'(res_data), 32'(exp_data));
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic do_word(input logic [15:0] d, input logic p, input logic exp_err);
        accept(d, p);
        wait_result(exp_err, d);
        handshake();
    endtask

    logic [15:0] odd_tbl;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_parity = 1'b0;
        res_ready = 1'b0;
        clr_count = 1'b0;
        odd_tbl   = 16'h6996;

        // 1. reset
        tick();
        check("in_ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);

        // 2. all zeros passes
        do_word(16'h0000, 1'b0, 1'b0);
        check("cnt_after_zero", 32'(err_count), 32'd0);

        // 3. single one fails; three ones plus parity passes
        do_word(16'h0001, 1'b0, 1'b1);
        check("cnt_after_0001", 32'(err_count), 32'd1);
        do_word(16'h0007, 1'b1, 1'b0);
        check("cnt_after_0007", 32'(err_count), 32'd1);

        // 4. low-nibble sweep
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_before_sweep", 32'(err_count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_word(16'(i), 1'b0, odd_tbl[i]);
        end
        check("cnt_after_sweep", 32'(err_count), 32'd8);
        check("cnt2_after_sweep", 32'(err_count2), 32'd3);

        // 5. backpressure: result held, second word waits
        accept(16'hA5A4, 1'b0);
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_parity = 1'b1;
        wait_result(1'b1, 16'hA5A4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_err", 32'(res_err), 32'd1);
            check("hold_res_data", 32'(res_data), 32'hA5A4);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_res_valid_drop", 32'(res_valid), 32'd0);
        check("bp_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_busy", 32'(busy), 32'd1);
        wait_result(1'b0, 16'h1234);
        handshake();
        check("cnt_after_bp", 32'(err_count), 32'd9);

        // 6. saturation, clear priority, mid-scan reset
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_cnt", 32'(err_count), 32'd0);
        check("clr_cnt2", 32'(err_count2), 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_word(16'h0001, 1'b0, 1'b1);
        end
        check("sat_cnt2", 32'(err_count2), 32'd3);
        check("nosat_cnt", 32'(err_count), 32'd5);

        accept(16'h0001, 1'b0);
        wait_result(1'b1, 16'h0001);
        res_ready = 1'b1;
        clr_count = 1'b1;
        tick();
        res_ready = 1'b0;
        clr_count = 1'b0;
        check("clr_wins_cnt", 32'(err_count), 32'd0);
        check("clr_wins_cnt2", 32'(err_count2), 32'd0);

        accept(16'h0001, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("in_ready_rst_mid", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_result", 32'(res_valid), 32'd0);
        end
        check("abort_cnt", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
